readonly_cache_axi: RTL

- Parametrised N-way set-associative read-only cache with an integrated AXI4 read master. No separate bridge block.
- Serves word reads from the fetch/load side with a valid/ready request and response handshake.
- Adds three features the previous generation lacks:
  - an uncached pass-through mode;
  - whole-cache invalidate;
  - AXI error reporting.
- Sits between the core fetch unit and the memory interconnect.

---
 rtl/readonly_cache_axi.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/readonly_cache_axi.sv
// readonly_cache_axi: N-way set-associative read-only cache with an integrated
// AXI4 read master. One outstanding request, optional uncached pass-through,
// whole-cache invalidate and AXI error reporting on the response channel.
module readonly_cache_axi #(
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_ADDRESS_WIDTH = 32,
    parameter int C_LINE_WORDS    = 4,
    parameter int C_SETS          = 4,
    parameter int C_WAYS          = 2
) (
    input  logic                       CLK,
    input  logic                       RES,
    input  logic [C_ADDRESS_WIDTH-1:0] S_RADDR,
    input  logic                       S_UNCACHED,
    input  logic                       S_ARVALID,
    output logic                       S_ARREADY,
    output logic [C_DATA_WIDTH-1:0]    S_RDATA,
    output logic                       S_RERR,
    output logic                       S_RVALID,
    input  logic                       S_RREADY,
    input  logic                       S_INVALIDATE,
    output logic [C_ADDRESS_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                 M_AXI_ARLEN,
    output logic [2:0]                 M_AXI_ARSIZE,
    output logic [1:0]                 M_AXI_ARBURST,
    output logic                       M_AXI_ARVALID,
    input  logic                       M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]    M_AXI_RDATA,
    input  logic [1:0]                 M_AXI_RRESP,
    input  logic                       M_AXI_RLAST,
    input  logic                       M_AXI_RVALID,
    output logic                       M_AXI_RREADY
);

    localparam int BYTE_W = $clog2(C_DATA_WIDTH / 8);
    localparam int WOFF_W = $clog2(C_LINE_WORDS);
    localparam int OFF_W  = WOFF_W + BYTE_W;
    localparam int IDX_W  = $clog2(C_SETS);
    localparam int TAG_W  = C_ADDRESS_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W  = (C_WAYS > 1) ? $clog2(C_WAYS) : 1;

    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(C_WAYS - 1);
    localparam logic [7:0]       LINE_LEN  = 8'(C_LINE_WORDS - 1);
    localparam logic [2:0]       BEAT_SIZE = 3'(BYTE_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        AR     = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4,
        INV    = 3'd5
    } state_t;

    // Storage: data and tags need no reset, valid bits and victim pointers do.
    logic [C_DATA_WIDTH-1:0] data_mem_r [C_WAYS][C_SETS][C_LINE_WORDS];
    logic [TAG_W-1:0]        tag_mem_r  [C_WAYS][C_SETS];
    logic                    valid_r    [C_WAYS][C_SETS];
    logic [WAY_W-1:0]        ptr_r      [C_SETS];

    // Control and registered-output state.
    state_t                      state_r,   state_nxt_s;
    logic [C_ADDRESS_WIDTH-1:0]  addr_r,    addr_nxt_s;
    logic                        unc_r,     unc_nxt_s;
    logic                        phase_r,   phase_nxt_s;
    logic                        hit_r,     hit_nxt_s;
    logic [WAY_W-1:0]            hit_way_r, hit_way_nxt_s;
    logic [WAY_W-1:0]            victim_r,  victim_nxt_s;
    logic [WOFF_W-1:0]           cnt_r,     cnt_nxt_s;
    logic                        err_r,     err_nxt_s;
    logic                        inv_pend_r, inv_pend_nxt_s;
    logic                        arready_r, arready_nxt_s;
    logic                        rvalid_r,  rvalid_nxt_s;
    logic                        rerr_r,    rerr_nxt_s;
    logic [C_DATA_WIDTH-1:0]     rdata_r,   rdata_nxt_s;
    logic                        arvalid_r, arvalid_nxt_s;
    logic                        rready_r,  rready_nxt_s;
    logic [C_ADDRESS_WIDTH-1:0]  araddr_r,  araddr_nxt_s;
    logic [7:0]                  arlen_r,   arlen_nxt_s;

    // Decoded request fields and helper strobes.
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [WOFF_W-1:0] woff_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic [WAY_W-1:0]  victim_s;
    logic              err_beat_s;
    logic              line_done_s;
    logic              clear_valid_s;
    logic              line_kill_s;
    logic              fill_write_s;
    logic              unused_s;

    assign idx_s    = addr_r[OFF_W +: IDX_W];
    assign tag_s    = addr_r[C_ADDRESS_WIDTH-1 -: TAG_W];
    assign woff_s   = addr_r[BYTE_W +: WOFF_W];
    assign unused_s = M_AXI_RRESP[0];

    // Parallel tag compare across all ways; lowest matching way wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        for (int w = C_WAYS - 1; w >= 0; w--) begin
            if (valid_r[w][idx_s] && (tag_mem_r[w][idx_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim_s = ptr_r[idx_s];
        for (int w = C_WAYS - 1; w >= 0; w--) begin
            if (!valid_r[w][idx_s]) begin
                victim_s = WAY_W'(w);
            end else begin
                victim_s = victim_s;
            end
        end
    end

    // Next-state and next-output logic for the controller.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        unc_nxt_s      = unc_r;
        phase_nxt_s    = phase_r;
        hit_nxt_s      = hit_r;
        hit_way_nxt_s  = hit_way_r;
        victim_nxt_s   = victim_r;
        cnt_nxt_s      = cnt_r;
        err_nxt_s      = err_r;
        inv_pend_nxt_s = inv_pend_r | S_INVALIDATE;
        rvalid_nxt_s   = rvalid_r;
        rerr_nxt_s     = rerr_r;
        rdata_nxt_s    = rdata_r;
        arvalid_nxt_s  = arvalid_r;
        rready_nxt_s   = rready_r;
        araddr_nxt_s   = araddr_r;
        arlen_nxt_s    = arlen_r;
        err_beat_s     = err_r;
        line_done_s    = 1'b0;
        clear_valid_s  = 1'b0;
        line_kill_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (inv_pend_r) begin
                    state_nxt_s = INV;
                end else if (S_ARVALID && arready_r) begin
                    addr_nxt_s  = S_RADDR;
                    unc_nxt_s   = S_UNCACHED;
                    phase_nxt_s = 1'b0;
                    state_nxt_s = LOOKUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOOKUP: begin
                // First cycle registers the compare, second cycle acts on it.
                if (!phase_r) begin
                    phase_nxt_s   = 1'b1;
                    hit_nxt_s     = hit_s;
                    hit_way_nxt_s = hit_way_s;
                end else if (unc_r) begin
                    araddr_nxt_s  = addr_r;
                    arlen_nxt_s   = 8'd0;
                    arvalid_nxt_s = 1'b1;
                    state_nxt_s   = AR;
                end else if (hit_r) begin
                    rdata_nxt_s  = data_mem_r[hit_way_r][idx_s][woff_s];
                    rerr_nxt_s   = 1'b0;
                    rvalid_nxt_s = 1'b1;
                    state_nxt_s  = RESP;
                end else begin
                    araddr_nxt_s  = {addr_r[C_ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    arlen_nxt_s   = LINE_LEN;
                    arvalid_nxt_s = 1'b1;
                    victim_nxt_s  = victim_s;
                    state_nxt_s   = AR;
                end
            end
            AR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    cnt_nxt_s     = '0;
                    err_nxt_s     = 1'b0;
                    line_kill_s   = !unc_r;
                    state_nxt_s   = FILL;
                end else begin
                    state_nxt_s = AR;
                end
            end
            FILL: begin
                if (M_AXI_RVALID) begin
                    if (unc_r ? (cnt_r == '0) : (cnt_r == woff_s)) begin
                        rdata_nxt_s = M_AXI_RDATA;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    err_beat_s = err_r | M_AXI_RRESP[1];
                    err_nxt_s  = err_beat_s;
                    cnt_nxt_s  = cnt_r + WOFF_W'(1);
                    if (M_AXI_RLAST) begin
                        rready_nxt_s = 1'b0;
                        rvalid_nxt_s = 1'b1;
                        rerr_nxt_s   = err_beat_s;
                        line_done_s  = !unc_r && !err_beat_s;
                        state_nxt_s  = RESP;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            RESP: begin
                if (S_RREADY) begin
                    rvalid_nxt_s = 1'b0;
                    rerr_nxt_s   = 1'b0;
                    err_nxt_s    = 1'b0;
                    state_nxt_s  = inv_pend_nxt_s ? INV : IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            INV: begin
                clear_valid_s  = 1'b1;
                inv_pend_nxt_s = S_INVALIDATE;
                state_nxt_s    = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        arready_nxt_s = (state_nxt_s == IDLE) && !inv_pend_nxt_s;
    end

    assign fill_write_s = (state_r == FILL) && M_AXI_RVALID && !unc_r;

    // Controller and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            unc_r      <= 1'b0;
            phase_r    <= 1'b0;
            hit_r      <= 1'b0;
            hit_way_r  <= '0;
            victim_r   <= '0;
            cnt_r      <= '0;
            err_r      <= 1'b0;
            inv_pend_r <= 1'b0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rerr_r     <= 1'b0;
            rdata_r    <= '0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            araddr_r   <= '0;
            arlen_r    <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            unc_r      <= unc_nxt_s;
            phase_r    <= phase_nxt_s;
            hit_r      <= hit_nxt_s;
            hit_way_r  <= hit_way_nxt_s;
            victim_r   <= victim_nxt_s;
            cnt_r      <= cnt_nxt_s;
            err_r      <= err_nxt_s;
            inv_pend_r <= inv_pend_nxt_s;
            arready_r  <= arready_nxt_s;
            rvalid_r   <= rvalid_nxt_s;
            rerr_r     <= rerr_nxt_s;
            rdata_r    <= rdata_nxt_s;
            arvalid_r  <= arvalid_nxt_s;
            rready_r   <= rready_nxt_s;
            araddr_r   <= araddr_nxt_s;
            arlen_r    <= arlen_nxt_s;
        end
    end

    // Valid bits and victim pointers; the victim line is invalidated while it
    // is being overwritten so an errored fill leaves it invalid.
    always_ff @(posedge CLK) begin
        if (RES || clear_valid_s) begin
            for (int w = 0; w < C_WAYS; w++) begin
                for (int s = 0; s < C_SETS; s++) begin
                    valid_r[w][s] <= 1'b0;
                end
            end
            if (RES) begin
                for (int s = 0; s < C_SETS; s++) begin
                    ptr_r[s] <= '0;
                end
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (line_kill_s) begin
            valid_r[victim_r][idx_s] <= 1'b0;
        end else if (line_done_s) begin
            valid_r[victim_r][idx_s] <= 1'b1;
            ptr_r[idx_s] <= (ptr_r[idx_s] == LAST_WAY) ? '0 : (ptr_r[idx_s] + WAY_W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Line data and tag storage written during fills.
    always_ff @(posedge CLK) begin
        if (fill_write_s) begin
            data_mem_r[victim_r][idx_s][cnt_r] <= M_AXI_RDATA;
        end else begin
            data_mem_r <= data_mem_r;
        end
        if (line_done_s) begin
            tag_mem_r[victim_r][idx_s] <= tag_s;
        end else begin
            tag_mem_r <= tag_mem_r;
        end
    end

    assign S_ARREADY     = arready_r;
    assign S_RDATA       = rdata_r;
    assign S_RERR        = rerr_r;
    assign S_RVALID      = rvalid_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARLEN   = arlen_r;
    assign M_AXI_ARSIZE  = BEAT_SIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule
